// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 512-word synchronous memory between the CPU
// datapath port (cpu) and a debug/loader port (dbg).
// Requests are served one at a time with round-robin priority. Byte
// addresses become word indices. Accesses that are misaligned or out of
// range are rejected without touching memory.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   cpu_* / dbg_*               req/we/addr/wdata/wstrb in; gnt/ack/rdata/err out
//   mem_en/we/addr/wdata/wstrb  memory command, registered
//   mem_rdata                   memory read data, one cycle after mem_en
//   busy                        a transaction is in ISSUE or RESP
//   cpu_cnt, dbg_cnt            saturating count of completed transactions
module mem_arbiter #(
    parameter int unsigned MEM_WORDS = 512,
    parameter int unsigned IDX_W     = 9
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    input  logic [3:0]       cpu_wstrb,
    output logic             cpu_gnt,
    output logic             cpu_ack,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_err,

    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [31:0]      dbg_addr,
    input  logic [31:0]      dbg_wdata,
    input  logic [3:0]       dbg_wstrb,
    output logic             dbg_gnt,
    output logic             dbg_ack,
    output logic [31:0]      dbg_rdata,
    output logic             dbg_err,

    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata,

    output logic             busy,
    output logic [15:0]      cpu_cnt,
    output logic [15:0]      dbg_cnt
);

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned ADDR_LIM = MEM_WORDS * 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               last_q, last_d;     // 1: dbg was granted last
    logic               owner_q, owner_d;   // 1: dbg owns the transaction
    logic               we_q, we_d;
    logic               bad_q, bad_d;
    logic               cpu_gnt_q, cpu_gnt_d;
    logic               dbg_gnt_q, dbg_gnt_d;
    logic               cpu_ack_q, cpu_ack_d;
    logic               dbg_ack_q, dbg_ack_d;
    logic               cpu_err_q, cpu_err_d;
    logic               dbg_err_q, dbg_err_d;
    logic               cpu_rd_q, cpu_rd_d;  // ack carries memory read data
    logic               dbg_rd_q, dbg_rd_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [IDX_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_wstrb_q, mem_wstrb_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cpu_cnt_q, cpu_cnt_d;
    logic [CNT_W-1:0]   dbg_cnt_q, dbg_cnt_d;

    logic               pick_dbg;
    logic               any_req;
    logic               sel_we;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic [3:0]         sel_wstrb;
    logic               sel_bad;

    // Round-robin winner and its command, used at arbitration points.
    always_comb begin
        any_req   = cpu_req | dbg_req;
        pick_dbg  = dbg_req & (~cpu_req | ~last_q);
        sel_we    = pick_dbg ? dbg_we    : cpu_we;
        sel_addr  = pick_dbg ? dbg_addr  : cpu_addr;
        sel_wdata = pick_dbg ? dbg_wdata : cpu_wdata;
        sel_wstrb = pick_dbg ? dbg_wstrb : cpu_wstrb;
        sel_bad   = (sel_addr[1:0] != 2'b00) || (sel_addr >= 32'(ADDR_LIM));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        we_d        = we_q;
        bad_d       = bad_q;
        cpu_gnt_d   = 1'b0;
        dbg_gnt_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        cpu_err_d   = 1'b0;
        dbg_err_d   = 1'b0;
        cpu_rd_d    = 1'b0;
        dbg_rd_d    = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_wstrb_d = '0;
        cpu_cnt_d   = cpu_cnt_q;
        dbg_cnt_d   = dbg_cnt_q;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (any_req) begin
                    state_d   = ST_ISSUE;
                    owner_d   = pick_dbg;
                    last_d    = pick_dbg;
                    we_d      = sel_we;
                    bad_d     = sel_bad;
                    cpu_gnt_d = ~pick_dbg;
                    dbg_gnt_d = pick_dbg;
                    // Rejected accesses never reach the memory.
                    if (!sel_bad) begin
                        mem_en_d   = 1'b1;
                        mem_we_d   = sel_we;
                        mem_addr_d = sel_addr[IDX_W+1:2];
                        if (sel_we) begin
                            mem_wdata_d = sel_wdata;
                            mem_wstrb_d = sel_wstrb;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
                if (owner_q) begin
                    dbg_ack_d = 1'b1;
                    dbg_err_d = bad_q;
                    dbg_rd_d  = ~bad_q & ~we_q;
                    if (dbg_cnt_q != {CNT_W{1'b1}}) begin
                        dbg_cnt_d = dbg_cnt_q + CNT_W'(1);
                    end
                end else begin
                    cpu_ack_d = 1'b1;
                    cpu_err_d = bad_q;
                    cpu_rd_d  = ~bad_q & ~we_q;
                    if (cpu_cnt_q != {CNT_W{1'b1}}) begin
                        cpu_cnt_d = cpu_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            bad_q       <= 1'b0;
            cpu_gnt_q   <= 1'b0;
            dbg_gnt_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            dbg_err_q   <= 1'b0;
            cpu_rd_q    <= 1'b0;
            dbg_rd_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            busy_q      <= 1'b0;
            cpu_cnt_q   <= '0;
            dbg_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            bad_q       <= bad_d;
            cpu_gnt_q   <= cpu_gnt_d;
            dbg_gnt_q   <= dbg_gnt_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            cpu_err_q   <= cpu_err_d;
            dbg_err_q   <= dbg_err_d;
            cpu_rd_q    <= cpu_rd_d;
            dbg_rd_q    <= dbg_rd_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            busy_q      <= busy_d;
            cpu_cnt_q   <= cpu_cnt_d;
            dbg_cnt_q   <= dbg_cnt_d;
        end
    end

    assign cpu_gnt   = cpu_gnt_q;
    assign dbg_gnt   = dbg_gnt_q;
    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign cpu_err   = cpu_err_q;
    assign dbg_err   = dbg_err_q;
    // Memory data arrives in RESP, so it is gated by a registered enable.
    assign cpu_rdata = cpu_rd_q ? mem_rdata : 32'h0;
    assign dbg_rdata = dbg_rd_q ? mem_rdata : 32'h0;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign busy      = busy_q;
    assign cpu_cnt   = cpu_cnt_q;
    assign dbg_cnt   = dbg_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: behavioural synchronous memory, a reference
// memory image, and per-port scoreboards of expected ack results.
module tb_mem_arbiter;

    localparam int unsigned MEM_WORDS = 512;
    localparam int unsigned IDX_W     = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0]      cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]       cpu_wstrb = '0;
    logic             cpu_gnt, cpu_ack, cpu_err;
    logic [31:0]      cpu_rdata;
    logic             dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0]      dbg_addr = '0, dbg_wdata = '0;
    logic [3:0]       dbg_wstrb = '0;
    logic             dbg_gnt, dbg_ack, dbg_err;
    logic [31:0]      dbg_rdata;
    logic             mem_en, mem_we;
    logic [IDX_W-1:0] mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wstrb;
    logic [31:0]      mem_rdata = '0;
    logic             busy;
    logic [15:0]      cpu_cnt, dbg_cnt;

    mem_arbiter #(.MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_gnt(cpu_gnt),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_wstrb(dbg_wstrb), .dbg_gnt(dbg_gnt),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .busy(busy), .cpu_cnt(cpu_cnt), .dbg_cnt(dbg_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    exp_t        cpu_q[$];
    exp_t        dbg_q[$];
    int          n_run = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          exp_cpu_cnt = 0, exp_dbg_cnt = 0;
    int          cpu_ack_cyc = 0, dbg_ack_cyc = 0, dbg_ack_prev = 0;
    logic [31:0] last_cpu_rdata = '0, last_dbg_rdata = '0;
    logic        mem_en_seen = 1'b0;
    exp_t        mon_e;

    // Memory under the arbiter: synchronous read, byte-strobed write.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
            mem_rdata <= mem[mem_addr];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference result of one access; updates the reference image on writes.
    function automatic exp_t model(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] wstrb);
        exp_t e;
        logic [IDX_W-1:0] i;
        e.err   = (addr[1:0] != 2'b00) || (addr >= 32'h0000_0800);
        e.rdata = '0;
        i       = addr[IDX_W+1:2];
        if (!e.err) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) ref_mem[i][8*b +: 8] = wdata[8*b +: 8];
                end
            end else begin
                e.rdata = ref_mem[i];
            end
        end
        return e;
    endfunction

    // Scoreboard: pop and compare on every ack.
    always @(negedge clk) begin
        if (rst_n && cpu_ack) begin
            n_run++;
            cpu_ack_cyc    = cyc;
            last_cpu_rdata = cpu_rdata;
            if (cpu_q.size() == 0) begin
                n_fail++;
                $display("FAIL cpu_ack_unexpected: got ack err=%0b rdata=%h, none outstanding", cpu_err, cpu_rdata);
            end else begin
                mon_e = cpu_q.pop_front();
                if (exp_cpu_cnt < 65535) exp_cpu_cnt++;
                if ({cpu_err, cpu_rdata} !== mon_e) begin
                    n_fail++;
                    $display("FAIL cpu_resp: got err=%0b rdata=%h, want err=%0b rdata=%h", cpu_err, cpu_rdata, mon_e.err, mon_e.rdata);
                end
                n_run++;
                if (cpu_cnt !== 16'(exp_cpu_cnt)) begin
                    n_fail++;
                    $display("FAIL cpu_cnt: got %0d want %0d", cpu_cnt, exp_cpu_cnt);
                end
            end
        end
        if (rst_n && dbg_ack) begin
            n_run++;
            dbg_ack_prev   = dbg_ack_cyc;
            dbg_ack_cyc    = cyc;
            last_dbg_rdata = dbg_rdata;
            if (dbg_q.size() == 0) begin
                n_fail++;
                $display("FAIL dbg_ack_unexpected: got ack err=%0b rdata=%h, none outstanding", dbg_err, dbg_rdata);
            end else begin
                mon_e = dbg_q.pop_front();
                if (exp_dbg_cnt < 65535) exp_dbg_cnt++;
                if ({dbg_err, dbg_rdata} !== mon_e) begin
                    n_fail++;
                    $display("FAIL dbg_resp: got err=%0b rdata=%h, want err=%0b rdata=%h", dbg_err, dbg_rdata, mon_e.err, mon_e.rdata);
                end
                n_run++;
                if (dbg_cnt !== 16'(exp_dbg_cnt)) begin
                    n_fail++;
                    $display("FAIL dbg_cnt: got %0d want %0d", dbg_cnt, exp_dbg_cnt);
                end
            end
        end
        if (mem_en) mem_en_seen = 1'b1;
    end

    // Holds reset for two edges; leaves the bench just after a rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        cpu_q.delete();
        dbg_q.delete();
        exp_cpu_cnt = 0;
        exp_dbg_cnt = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drives one command (called just after a rising edge), waits for gnt,
    // then releases req unless the caller chains another command.
    task automatic issue(input bit is_dbg, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb, input bit chain,
                         output int lat, output logic m_en, output logic m_we,
                         output logic [IDX_W-1:0] m_addr);
        exp_t e;
        logic g;
        e = model(we, addr, wdata, wstrb);
        if (is_dbg) begin
            dbg_q.push_back(e);
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_wstrb = wstrb;
        end else begin
            cpu_q.push_back(e);
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
        end
        lat = 0;
        g   = 1'b0;
        while (!g && lat < 20) begin
            @(negedge clk);
            lat++;
            g = is_dbg ? dbg_gnt : cpu_gnt;
        end
        if (!g) begin
            n_run++;
            n_fail++;
            $display("FAIL gnt_timeout: port=%0d got no gnt within %0d cycles, want gnt", is_dbg, lat);
        end
        m_en   = mem_en;
        m_we   = mem_we;
        m_addr = mem_addr;
        @(posedge clk);
        #1;
        if (!chain) begin
            if (is_dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
        end
    endtask

    // Waits, bounded, until all expected acks have arrived and the DUT is idle.
    task automatic wait_done();
        int n = 0;
        while ((cpu_q.size() != 0 || dbg_q.size() != 0 || busy) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            n_run++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d cpu/%0d dbg pending busy=%0b, want none", cpu_q.size(), dbg_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        int lat;
        logic en, we;
        logic [IDX_W-1:0] ad;
        #2 rst_n = 1'b0;
        #1;
        n_run++;
        if ({cpu_gnt, cpu_ack, cpu_err, cpu_rdata, dbg_gnt, dbg_ack, dbg_err, dbg_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, busy, cpu_cnt, dbg_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero outputs busy=%0b cpu_cnt=%0d, want all 0", busy, cpu_cnt);
        end
        mem[0] = 32'h0000_0513;
        ref_mem[0] = 32'h0000_0513;
        do_reset();
        issue(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, lat, en, we, ad);
        n_run++;
        if (lat !== 2 || en !== 1'b1 || ad !== '0) begin
            n_fail++;
            $display("FAIL single_read_issue: got lat=%0d en=%0b addr=%0d, want lat=2 en=1 addr=0", lat, en, ad);
        end
        wait_done();
        n_run++;
        if (last_cpu_rdata !== 32'h0000_0513 || cpu_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL single_read_data: got rdata=%h cnt=%0d, want 00000513 cnt=1", last_cpu_rdata, cpu_cnt);
        end
    endtask

    task automatic test_dbg_load();
        int lat;
        logic en, we;
        logic [IDX_W-1:0] ad;
        issue(1'b1, 1'b1, 32'h4, 32'h020f_8663, 4'hF, 1'b1, lat, en, we, ad);
        n_run++;
        if (lat !== 2 || en !== 1'b1 || we !== 1'b1 || ad !== 9'd1) begin
            n_fail++;
            $display("FAIL dbg_write_issue: got lat=%0d en=%0b we=%0b addr=%0d, want 2 1 1 1", lat, en, we, ad);
        end
        issue(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, lat, en, we, ad);
        n_run++;
        if (lat !== 2 || we !== 1'b0 || ad !== 9'd1) begin
            n_fail++;
            $display("FAIL dbg_read_issue: got lat=%0d we=%0b addr=%0d, want 2 0 1", lat, we, ad);
        end
        wait_done();
        n_run++;
        if (dbg_ack_cyc - dbg_ack_prev !== 2 || last_dbg_rdata !== 32'h020f_8663) begin
            n_fail++;
            $display("FAIL dbg_back_to_back: got spacing=%0d rdata=%h, want 2 020f8663", dbg_ack_cyc - dbg_ack_prev, last_dbg_rdata);
        end
    endtask

    task automatic test_contention();
        int gcyc[8];
        bit gdbg[8];
        int ng = 0;
        int n = 0;
        cpu_we = 1'b0; cpu_addr = 32'h0;
        dbg_we = 1'b0; dbg_addr = 32'h4;
        cpu_req = 1'b1;
        dbg_req = 1'b1;
        do_reset();
        while (ng < 8 && n < 40) begin
            @(negedge clk);
            n++;
            n_run++;
            if (cpu_gnt && dbg_gnt) begin
                n_fail++;
                $display("FAIL both_gnt: got cpu_gnt=1 dbg_gnt=1, want at most one");
            end
            if (cpu_gnt) cpu_q.push_back(model(1'b0, 32'h0, 32'h0, 4'h0));
            if (dbg_gnt) dbg_q.push_back(model(1'b0, 32'h4, 32'h0, 4'h0));
            if (cpu_gnt || dbg_gnt) begin
                gcyc[ng] = cyc;
                gdbg[ng] = dbg_gnt;
                ng++;
            end
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        wait_done();
        for (int i = 0; i < 8; i++) begin
            n_run++;
            if (i >= ng || gdbg[i] !== 1'(i % 2) || (i > 0 && gcyc[i] - gcyc[i-1] != 2)) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got dbg=%0b spacing=%0d (grants=%0d), want dbg=%0d spacing=2", i, gdbg[i], (i > 0) ? gcyc[i] - gcyc[i-1] : 0, ng, i % 2);
            end
        end
    endtask

    task automatic test_errors();
        int lat;
        logic en, we;
        logic [IDX_W-1:0] ad;
        int base;
        base = exp_cpu_cnt;
        mem_en_seen = 1'b0;
        issue(1'b0, 1'b0, 32'h802, 32'h0, 4'h0, 1'b0, lat, en, we, ad);
        n_run++;
        if (lat !== 2 || en !== 1'b0) begin
            n_fail++;
            $display("FAIL err_misaligned_issue: got lat=%0d mem_en=%0b, want 2 0", lat, en);
        end
        wait_done();
        issue(1'b0, 1'b0, 32'h800, 32'h0, 4'h0, 1'b0, lat, en, we, ad);
        wait_done();
        n_run++;
        if (mem_en_seen !== 1'b0 || cpu_cnt !== 16'(base + 2)) begin
            n_fail++;
            $display("FAIL err_no_mem: got mem_en_seen=%0b cnt=%0d, want 0 %0d", mem_en_seen, cpu_cnt, base + 2);
        end
    endtask

    task automatic test_byte_strobe();
        int lat;
        logic en, we;
        logic [IDX_W-1:0] ad;
        mem[3] = 32'hFFFF_FFFF;
        ref_mem[3] = 32'hFFFF_FFFF;
        issue(1'b1, 1'b1, 32'hC, 32'h0000_0012, 4'h1, 1'b1, lat, en, we, ad);
        issue(1'b1, 1'b0, 32'hC, 32'h0, 4'h0, 1'b0, lat, en, we, ad);
        wait_done();
        n_run++;
        if (last_dbg_rdata !== 32'hFFFF_FF12) begin
            n_fail++;
            $display("FAIL byte_strobe: got %h want ffffff12", last_dbg_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int n = 0;
        logic en, we;
        logic [IDX_W-1:0] ad;
        mem[4] = 32'hA5A5_A5A5;
        ref_mem[4] = 32'hA5A5_A5A5;
        dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'h1111_1111; dbg_wstrb = 4'hF;
        dbg_req = 1'b1;
        while (!dbg_gnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        dbg_req = 1'b0;
        cpu_q.delete();
        dbg_q.delete();
        exp_cpu_cnt = 0;
        exp_dbg_cnt = 0;
        #1;
        n_run++;
        if (n >= 20 || {cpu_gnt, cpu_ack, cpu_err, cpu_rdata, dbg_gnt, dbg_ack, dbg_err, dbg_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, busy, cpu_cnt, dbg_cnt} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got gnt_wait=%0d mem_en=%0b busy=%0b dbg_cnt=%0d, want all 0", n, mem_en, busy, dbg_cnt);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_run++;
        if (busy !== 1'b0 || mem[4] !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL mid_reset_state: got busy=%0b word4=%h, want 0 a5a5a5a5", busy, mem[4]);
        end
        issue(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, lat, en, we, ad);
        n_run++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL mid_reset_recover: got lat=%0d want 2", lat);
        end
        wait_done();
    endtask

    initial begin
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        test_reset();
        test_dbg_load();
        test_contention();
        test_errors();
        test_byte_strobe();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
